// File: rtl/silife_max7219_pkg.sv
// Shared MAX7219 register map, read-port config packing and receiver state type.
// Used by both the matrix driver and the receive-side chain model.
package silife_max7219_pkg;

  localparam logic [3:0] REG_NOOP      = 4'h0;
  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DIGIT1    = 4'h2;
  localparam logic [3:0] REG_DIGIT2    = 4'h3;
  localparam logic [3:0] REG_DIGIT3    = 4'h4;
  localparam logic [3:0] REG_DIGIT4    = 4'h5;
  localparam logic [3:0] REG_DIGIT5    = 4'h6;
  localparam logic [3:0] REG_DIGIT6    = 4'h7;
  localparam logic [3:0] REG_DIGIT7    = 4'h8;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  localparam int CFG_TEST_BIT      = 15;
  localparam int CFG_ENABLED_BIT   = 14;
  localparam int CFG_DECODE_BIT    = 13;
  localparam int CFG_SCAN_LSB      = 10;
  localparam int CFG_SCAN_W        = 3;
  localparam int CFG_INTENSITY_LSB = 6;
  localparam int CFG_INTENSITY_W   = 4;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_COMMIT
  } rx_state_e;

  // Digit registers 0x1..0x8 map onto row slots 0..7.
  function automatic logic [2:0] digit_index(input logic [3:0] addr);
    return 3'(addr - REG_DIGIT0);
  endfunction

endpackage

// File: rtl/silife_spi_slave_sync.sv
// SPI slave front end: input synchronisers, edge detection, frame FSM, shift register
// and saturating bit counter. Optional chain pass-through under SILIFE_MAX7219_RX_DOUT_EN.
module silife_spi_slave_sync
  import silife_max7219_pkg::*;
#(
  parameter int CHAIN       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  sck,
  input  logic                  mosi,
  output logic                  frame_end,
`ifdef SILIFE_MAX7219_RX_DOUT_EN
  output logic                  dout,
`endif
  output logic [15:0]           bit_count,
  output logic [16*CHAIN-1:0]   shift_data
);

  localparam int N  = 16 * CHAIN;
  localparam int SW = $clog2(SYNC_STAGES + 1);
  localparam logic [SW-1:0] SETTLE_DONE = SW'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   cs_s;
  logic                   sck_s;
  logic                   mosi_s;
  logic                   sck_prev;
  logic                   sck_rise;
  logic [SW-1:0]          settle_q;
  logic                   armed_q;
  logic                   start;
  rx_state_e              state_q;
  rx_state_e              state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_prev  <= sck_s;
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;

  // The synchroniser reset value reads as "CS high", so arming waits until the chain
  // holds real samples; a CS held low across reset release never starts a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      settle_q <= '0;
      armed_q  <= 1'b0;
      state_q  <= RX_IDLE;
    end else begin
      if (settle_q != SETTLE_DONE) settle_q <= settle_q + SW'(1);
      if (start) armed_q <= 1'b0;
      else if (settle_q == SETTLE_DONE && cs_s) armed_q <= 1'b1;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (armed_q && !cs_s) begin
          state_d = RX_SHIFT;
          start   = 1'b1;
        end
      end
      RX_SHIFT: begin
        if (cs_s) begin
          state_d   = RX_COMMIT;
          frame_end = 1'b1;
        end
      end
      RX_COMMIT: state_d = RX_IDLE;
      default:   state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_data <= '0;
      bit_count  <= '0;
    end else if (start) begin
      bit_count <= '0;
    end else if (state_q == RX_SHIFT && !cs_s && sck_rise) begin
      shift_data <= {shift_data[N-2:0], mosi_s};
      if (bit_count != 16'hffff) bit_count <= bit_count + 16'd1;
    end
  end

`ifdef SILIFE_MAX7219_RX_DOUT_EN
  logic sck_fall;
  assign sck_fall = ~sck_s & sck_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dout <= 1'b0;
    else if (sck_fall) dout <= shift_data[N-1];
  end
`endif

endmodule

// File: rtl/silife_max7219_rx.sv
// MAX7219-compatible daisy-chain receiver: decodes each device's word on CS rise.
// Optional o_dout chain pass-through enabled by SILIFE_MAX7219_RX_DOUT_EN.
module silife_max7219_rx
  import silife_max7219_pkg::*;
#(
  parameter int CHAIN       = 16,
  parameter int SYNC_STAGES = 2,
  localparam int DEV_W      = (CHAIN > 1) ? $clog2(CHAIN) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cs,
  input  logic             i_sck,
  input  logic             i_mosi,
  input  logic [DEV_W-1:0] i_rd_dev,
  input  logic [2:0]       i_rd_row,
  output logic [7:0]       o_rd_row_data,
  output logic [15:0]      o_rd_cfg,
  output logic             o_commit,
  output logic             o_frame_err,
`ifdef SILIFE_MAX7219_RX_DOUT_EN
  output logic             o_dout,
`endif
  output logic [15:0]      o_bit_count
);

  logic                 frame_end;
  logic                 frame_ok;
  logic                 commit_ok;
  logic [16*CHAIN-1:0]  shift_data;
  logic [7:0]           rows_q      [CHAIN][8];
  logic [CHAIN-1:0]     test_q;
  logic [CHAIN-1:0]     enabled_q;
  logic [CHAIN-1:0]     decode_q;
  logic [2:0]           scan_q      [CHAIN];
  logic [3:0]           intensity_q [CHAIN];

  silife_spi_slave_sync #(
    .CHAIN       (CHAIN),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .cs         (i_cs),
    .sck        (i_sck),
    .mosi       (i_mosi),
    .frame_end  (frame_end),
`ifdef SILIFE_MAX7219_RX_DOUT_EN
    .dout       (o_dout),
`endif
    .bit_count  (o_bit_count),
    .shift_data (shift_data)
  );

  assign frame_ok  = (o_bit_count != 16'd0) && (o_bit_count[3:0] == 4'd0);
  assign commit_ok = frame_end && frame_ok;

  // Registers update on the same edge that raises o_commit, so the read port already
  // shows the new frame while the pulse is high. Device 0 holds the last word shifted in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < CHAIN; k++) begin
        for (int r = 0; r < 8; r++) rows_q[k][r] <= '0;
        scan_q[k]      <= '0;
        intensity_q[k] <= '0;
      end
      test_q      <= '0;
      enabled_q   <= '0;
      decode_q    <= '0;
      o_commit    <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_commit <= commit_ok;
      if (frame_end) o_frame_err <= !frame_ok;
      if (commit_ok) begin
        for (int k = 0; k < CHAIN; k++) begin
          case (shift_data[16*k+8 +: 4])
            REG_NOOP: ;
            REG_DIGIT0, REG_DIGIT1, REG_DIGIT2, REG_DIGIT3,
            REG_DIGIT4, REG_DIGIT5, REG_DIGIT6, REG_DIGIT7:
              rows_q[k][digit_index(shift_data[16*k+8 +: 4])] <= shift_data[16*k +: 8];
            REG_DECODE:    decode_q[k]    <= |shift_data[16*k +: 8];
            REG_INTENSITY: intensity_q[k] <= shift_data[16*k +: 4];
            REG_SCANLIMIT: scan_q[k]      <= shift_data[16*k +: 3];
            REG_SHUTDOWN:  enabled_q[k]   <= shift_data[16*k];
            REG_TEST:      test_q[k]      <= shift_data[16*k];
            default: ;
          endcase
        end
      end
    end
  end

  assign o_rd_row_data = rows_q[i_rd_dev][i_rd_row];

  always_comb begin
    o_rd_cfg                                              = '0;
    o_rd_cfg[CFG_TEST_BIT]                                = test_q[i_rd_dev];
    o_rd_cfg[CFG_ENABLED_BIT]                             = enabled_q[i_rd_dev];
    o_rd_cfg[CFG_DECODE_BIT]                              = decode_q[i_rd_dev];
    o_rd_cfg[CFG_SCAN_LSB +: CFG_SCAN_W]                  = scan_q[i_rd_dev];
    o_rd_cfg[CFG_INTENSITY_LSB +: CFG_INTENSITY_W]        = intensity_q[i_rd_dev];
  end

endmodule

// File: tb/tb_silife_max7219_rx.sv
// Directed scoreboard bench for silife_max7219_rx with a 4-device chain.
// Expected commit/error/count outcomes are queued per frame and checked against a register model.
module tb_silife_max7219_rx;

  localparam int CHAIN       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int NB          = 16 * CHAIN;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_cs = 1'b1;
  logic        i_sck = 1'b0;
  logic        i_mosi = 1'b0;
  logic [1:0]  i_rd_dev = '0;
  logic [2:0]  i_rd_row = '0;
  logic [7:0]  o_rd_row_data;
  logic [15:0] o_rd_cfg;
  logic        o_commit;
  logic        o_frame_err;
  logic [15:0] o_bit_count;
`ifdef SILIFE_MAX7219_RX_DOUT_EN
  logic        o_dout;
`endif

  silife_max7219_rx #(
    .CHAIN       (CHAIN),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_cs          (i_cs),
    .i_sck         (i_sck),
    .i_mosi        (i_mosi),
    .i_rd_dev      (i_rd_dev),
    .i_rd_row      (i_rd_row),
    .o_rd_row_data (o_rd_row_data),
    .o_rd_cfg      (o_rd_cfg),
    .o_commit      (o_commit),
    .o_frame_err   (o_frame_err),
`ifdef SILIFE_MAX7219_RX_DOUT_EN
    .o_dout        (o_dout),
`endif
    .o_bit_count   (o_bit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit commit;
    bit err;
    int count;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;

  logic [NB-1:0] m_shift;
  int            m_cnt;
  bit            m_live;
  bit            m_err;
  logic [7:0]    m_rows [CHAIN][8];
  logic          m_test [CHAIN];
  logic          m_en   [CHAIN];
  logic          m_dec  [CHAIN];
  logic [2:0]    m_scan [CHAIN];
  logic [3:0]    m_int  [CHAIN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_cfg(input int d);
    return {m_test[d], m_en[d], m_dec[d], m_scan[d], m_int[d], 6'b0};
  endfunction

  task automatic model_reset();
    m_shift = '0;
    m_cnt   = 0;
    m_err   = 1'b0;
    for (int k = 0; k < CHAIN; k++) begin
      for (int r = 0; r < 8; r++) m_rows[k][r] = '0;
      m_test[k] = 1'b0;
      m_en[k]   = 1'b0;
      m_dec[k]  = 1'b0;
      m_scan[k] = '0;
      m_int[k]  = '0;
    end
  endtask

  task automatic model_commit();
    logic [15:0] w;
    int a;
    for (int k = 0; k < CHAIN; k++) begin
      w = m_shift[16*k +: 16];
      a = int'(w[11:8]);
      if (a >= 1 && a <= 8) m_rows[k][a-1] = w[7:0];
      else if (a == 9)  m_dec[k]  = |w[7:0];
      else if (a == 10) m_int[k]  = w[3:0];
      else if (a == 11) m_scan[k] = w[2:0];
      else if (a == 12) m_en[k]   = w[0];
      else if (a == 15) m_test[k] = w[0];
    end
  endtask

  task automatic spi_bit(input logic b);
    i_mosi = b;
    i_sck  = 1'b0;
    tick(3);
    i_sck = 1'b1;
    tick(3);
    i_sck = 1'b0;
    if (m_live) begin
      m_shift = {m_shift[NB-2:0], b};
      m_cnt++;
    end
  endtask

  // Drives one CS-low window; a non-live window is one the DUT must not treat as a frame.
  task automatic apply_stimulus(input logic [127:0] data, input int nbits, input bit live);
    bit ok;
    i_rd_dev = '0;
    i_rd_row = '0;
    m_live   = live;
    if (live) m_cnt = 0;
    i_cs = 1'b0;
    tick(4);
    for (int i = nbits - 1; i >= 0; i--) spi_bit(data[i]);
    tick(3);
    i_cs = 1'b1;
    if (live) begin
      ok = (m_cnt != 0) && (m_cnt % 16 == 0);
      if (ok) model_commit();
      m_err = !ok;
      exp_q.push_back('{commit: ok, err: !ok, count: m_cnt});
    end else begin
      exp_q.push_back('{commit: 1'b0, err: m_err, count: m_cnt});
    end
  endtask

  task automatic check_regs();
    for (int d = 0; d < CHAIN; d++) begin
      i_rd_dev = 2'(d);
      for (int r = 0; r < 8; r++) begin
        i_rd_row = 3'(r);
        #1;
        check($sformatf("row_d%0d_r%0d", d, r), 32'(o_rd_row_data), 32'(m_rows[d][r]));
      end
      check($sformatf("cfg_d%0d", d), 32'(o_rd_cfg), 32'(model_cfg(d)));
    end
    i_rd_dev = '0;
    i_rd_row = '0;
  endtask

  task automatic check_output();
    exp_t e;
    bit   seen;
    int   lat;
    logic [7:0]  row_at;
    logic [15:0] cfg_at;
    e      = exp_q.pop_front();
    seen   = 1'b0;
    lat    = 0;
    row_at = '0;
    cfg_at = '0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (o_commit === 1'b1 && !seen) begin
        seen   = 1'b1;
        lat    = i;
        row_at = o_rd_row_data;
        cfg_at = o_rd_cfg;
      end
    end
    check("commit_seen", 32'(seen), 32'(e.commit));
    if (e.commit) begin
      check("commit_latency", 32'(lat), 32'(SYNC_STAGES + 1));
      check("commit_row_same_cycle", 32'(row_at), 32'(m_rows[0][0]));
      check("commit_cfg_same_cycle", 32'(cfg_at), 32'(model_cfg(0)));
    end
    check("frame_err", 32'(o_frame_err), 32'(e.err));
    check("bit_count", 32'(o_bit_count), 32'(e.count));
    check_regs();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit commit_hit;

    model_reset();
    tick(3);
    check("reset_commit", 32'(o_commit), 32'd0);
    check("reset_frame_err", 32'(o_frame_err), 32'd0);
    check("reset_bit_count", 32'(o_bit_count), 32'd0);
    check_regs();
    #3;
    reset = 1'b1;
    tick(5);

    $display("[TB] SCK activity with CS high");
    commit_hit = 1'b0;
    repeat (4) begin
      i_sck = 1'b1;
      tick(3);
      i_sck = 1'b0;
      tick(3);
      if (o_commit === 1'b1) commit_hit = 1'b1;
    end
    tick(4);
    check("idle_sck_bit_count", 32'(o_bit_count), 32'd0);
    check("idle_sck_commit", 32'(commit_hit), 32'd0);
    check("idle_sck_frame_err", 32'(o_frame_err), 32'd0);

    $display("[TB] single word intensity");
    apply_stimulus(128'h0A05, 16, 1'b1);
    check_output();

    $display("[TB] four-device row fill");
    apply_stimulus(128'h0111_0122_0133_0144, 64, 1'b1);
    check_output();

    $display("[TB] malformed 15-bit frame then recovery");
    apply_stimulus(128'h0C01, 15, 1'b1);
    check_output();
    apply_stimulus(128'h0B05, 16, 1'b1);
    check_output();

    $display("[TB] overrun by one word");
    apply_stimulus(128'h0CAA_0C01_0F01_0901_0102, 80, 1'b1);
    check_output();

    $display("[TB] CS glitch with no bits");
    apply_stimulus(128'h0, 0, 1'b1);
    check_output();
    apply_stimulus(128'h0A0F_0B07_0C00_0803, 64, 1'b1);
    check_output();

    $display("[TB] reset in the middle of a frame");
    m_live = 1'b0;
    i_cs   = 1'b0;
    tick(4);
    for (int i = 7; i >= 0; i--) spi_bit(1'b1);
    #2;
    reset = 1'b0;
    model_reset();
    #2;
    check("midreset_commit", 32'(o_commit), 32'd0);
    check("midreset_frame_err", 32'(o_frame_err), 32'd0);
    check("midreset_bit_count", 32'(o_bit_count), 32'd0);
    check_regs();
    tick(2);
    reset = 1'b1;
    tick(2);
    apply_stimulus(128'h0C01, 16, 1'b0);
    check_output();
    apply_stimulus(128'h0C01_0C01_0C01_0C01, 64, 1'b1);
    check_output();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
